data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Multi-cycle data-memory target: the responder end of the core's load/store port.
//  Accepts one word-aligned read or write per valid/ready handshake.
//  Inserts LATENCY wait cycles, then returns a response held until rsp_ready.
//  Replaces the zero-latency data memory when the core is moved to a stallable memory interface.
// PARAMETERS
//  DEPTH_WORDS  64  number of 32-bit words; a power of two, >= 2
//  LATENCY       2  wait cycles between accept and response; range 0..15
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   synchronous, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept a request (high only in IDLE)
//  req_write   in   1   1 = store, 0 = load
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data
//  req_wstrb   in   4   byte enables; bit i enables wdata[8i+7:8i]
//  rsp_valid   out  1   response present
//  rsp_ready   in   1   requester accepts response
//  rsp_rdata   out  32  load data; 0 for stores and for errors
//  rsp_err     out  1   access was misaligned or out of range
// BEHAVIOUR
//  Clock and reset
//   - One clock domain: clk. Reset is synchronous and active-high, named reset.
//   - At a reset edge: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
//   - At a reset edge, every memory word is cleared to 0.
//   - Reset mid-transaction aborts it: no write is committed and no response is issued.
//  Word index and errors
//   - Word index = req_addr[$clog2(DEPTH_WORDS)+1:2].
//   - Error if req_addr[1:0] != 0, or if any bit of req_addr[31:$clog2(DEPTH_WORDS)+2] is set.
//   - An erroring access never writes memory, returns rsp_rdata=0 and rsp_err=1.
//  State machine (IDLE, WAIT, RESP)
//   - IDLE: req_ready=1. On req_valid at an edge, latch write/addr/wdata/wstrb.
//     If LATENCY==0, next state is RESP and the access executes at that same edge.
//     Otherwise next state is WAIT with counter=1.
//   - WAIT: req_ready=0. Counter increments each edge.
//     At the edge where counter==LATENCY, the access executes and next state is RESP.
//   - Access execution, same edge in all cases:
//     load:  rsp_rdata <= mem[idx].
//     store: for each i with wstrb[i]=1, mem[idx][8i+7:8i] <= wdata[8i+7:8i]; rsp_rdata <= 0.
//     rsp_err <= error flag.
//   - RESP: rsp_valid=1, rsp_rdata and rsp_err stable, req_ready=0.
//     At an edge with rsp_ready=1: next state IDLE, rsp_valid<=0, rsp_rdata<=0, rsp_err<=0.
//     With rsp_ready=0, stay in RESP indefinitely.
//  Latency and throughput
//   - Accept at edge E gives rsp_valid high after edge E+LATENCY (after E when LATENCY=0).
//   - Store data is visible to a load accepted at any later edge.
//   - No request is accepted in the same cycle as a response handshake.
//     Back-to-back throughput is therefore one access per LATENCY+2 cycles.
//  Other rules
//   - req_valid while req_ready=0 is ignored; the requester must hold it until accepted.
//   - A store with wstrb=0 completes normally, err=0, and leaves memory unchanged.
//   - Latched request fields never change between accept and response.
//     Input changes on req_* outside IDLE have no effect.
// TESTING
//  1. LATENCY=2: store 0xDEADBEEF to 0x10 with wstrb=F, then load 0x10
//     -> rsp_rdata=0xDEADBEEF, err=0; rsp_valid rises 2 edges after each accept.
//  2. Word 0x10 holds 0xDEADBEEF; store 0x00001234 to 0x10 with wstrb=0011; load 0x10
//     -> 0xDEAD1234.
//  3. Load 0x02 -> err=1, rdata=0. Store to 0x100 (DEPTH=64) -> err=1, and a load of 0x0 still reads 0.
//  4. Hold rsp_ready=0 for 5 cycles in RESP
//     -> rsp_valid, rdata and err stay stable and req_ready=0; the 6th edge with rsp_ready=1 returns to IDLE.
//  5. Assert reset during WAIT of a store of 0x55 to 0x8
//     -> outputs at reset values; a subsequent load of 0x8 returns 0 with no stray rsp_valid.
//  6. LATENCY=0: 8 back-to-back loads with rsp_ready tied high
//     -> one response every 2 cycles; addresses 0x0..0x1C return stored values in order.

Source files
------------

// File: rtl/data_mem_responder.sv
// Stallable data-memory target: accepts one load/store per request handshake, waits LATENCY
// cycles, then presents a response that is held until the requester takes it.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  // Request handshake: a request transfers at a rising edge where req_valid and req_ready are
  // both high; a response transfers at a rising edge where rsp_valid and rsp_ready are both high.
  localparam int         AW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wstrb;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          exec;
  logic          a_write;
  logic [31:0]   a_addr;
  logic [31:0]   a_wdata;
  logic [3:0]    a_wstrb;
  logic          a_err;
  logic [AW-1:0] a_idx;

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    exec       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            exec       = 1'b1;
            state_next = RESP;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == LAT) begin
          exec       = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // With zero latency the access executes on the accept edge, so it must use the live request.
  always_comb begin
    a_write = (state == IDLE) ? req_write : lat_write;
    a_addr  = (state == IDLE) ? req_addr  : lat_addr;
    a_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    a_wstrb = (state == IDLE) ? req_wstrb : lat_wstrb;
    a_idx   = a_addr[AW+1:2];
    a_err   = (a_addr[1:0] != 2'b00) || (|a_addr[31:AW+2]);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_wstrb <= req_wstrb;
        cnt       <= (LATENCY == 0) ? 4'd0 : 4'd1;
      end else if (state == WAIT) begin
        cnt <= exec ? 4'd0 : cnt + 4'd1;
      end
      if (exec) begin
        rsp_rdata <= (a_write || a_err) ? 32'h0 : mem[a_idx];
        rsp_err   <= a_err;
      end else if (state == RESP && rsp_ready) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (exec && a_write && !a_err) begin
      for (int i = 0; i < 4; i++) begin
        if (a_wstrb[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2 and a LATENCY=0 instance checked every cycle
// against a transaction-level model, plus directed scenarios with literal expectations.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // model: per instance, word memory plus the one outstanding transaction
  logic [31:0] m_mem [2][64];
  bit          m_busy [2];
  int          m_age  [2];
  logic [31:0] m_rd   [2];
  bit          m_er   [2];

  int acc_cyc [2];
  int rsp_cyc [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut_l2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) dut_l0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  function automatic int lat_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (reset) begin
        for (int i = 0; i < 64; i++) m_mem[u][i] = 32'h0;
        m_busy[u] = 1'b0;
        m_age[u]  = 0;
        m_rd[u]   = 32'h0;
        m_er[u]   = 1'b0;
      end else if (m_busy[u]) begin
        if (m_age[u] >= lat_of(u)) begin
          if (rsp_ready[u]) m_busy[u] = 1'b0;
        end else begin
          m_age[u]++;
        end
      end else if (req_valid[u]) begin
        int idx;
        idx = int'(req_addr[u][7:2]);
        m_er[u] = (req_addr[u][1:0] != 2'b00) || (req_addr[u][31:8] != 24'h0);
        m_rd[u] = 32'h0;
        if (!m_er[u]) begin
          if (req_write[u]) begin
            for (int b = 0; b < 4; b++)
              if (req_wstrb[u][b]) m_mem[u][idx][8*b +: 8] = req_wdata[u][8*b +: 8];
          end else begin
            m_rd[u] = m_mem[u][idx];
          end
        end
        m_busy[u] = 1'b1;
        m_age[u]  = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        bit ev;
        ev = m_busy[u] && (m_age[u] >= lat_of(u));
        chk($sformatf("u%0d req_ready", u), {31'h0, req_ready[u]}, {31'h0, !m_busy[u]});
        chk($sformatf("u%0d rsp_valid", u), {31'h0, rsp_valid[u]}, {31'h0, ev});
        chk($sformatf("u%0d rsp_rdata", u), rsp_rdata[u], ev ? m_rd[u] : 32'h0);
        chk($sformatf("u%0d rsp_err", u), {31'h0, rsp_err[u]}, {31'h0, ev && m_er[u]});
      end
    end
  end

  task automatic scramble(input int u);
    req_valid[u] = 1'($urandom_range(0, 1));
    req_write[u] = 1'($urandom_range(0, 1));
    req_addr[u]  = $urandom;
    req_wdata[u] = $urandom;
    req_wstrb[u] = 4'($urandom);
  endtask

  // Called at a falling edge; returns at the falling edge after the response handshake.
  task automatic access(input int u, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int stall,
                        output logic [31:0] rd, output logic er);
    int g;
    req_write[u] = w;
    req_addr[u]  = a;
    req_wdata[u] = d;
    req_wstrb[u] = s;
    req_valid[u] = 1'b1;
    rsp_ready[u] = 1'b0;
    g = 0;
    while (req_ready[u] !== 1'b1 && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (g >= 40) note_timeout("accept");
    acc_cyc[u] = cyc;
    @(posedge clk);
    @(negedge clk);
    scramble(u);
    if (stall == 0) rsp_ready[u] = 1'b1;
    g = 0;
    while (rsp_valid[u] !== 1'b1 && g < 40) begin
      @(negedge clk);
      scramble(u);
      g++;
    end
    if (g >= 40) note_timeout("response");
    rsp_cyc[u] = cyc;
    repeat (stall) begin
      @(negedge clk);
      scramble(u);
    end
    rsp_ready[u] = 1'b1;
    rd = rsp_rdata[u];
    er = rsp_err[u];
    @(posedge clk);
    @(negedge clk);
    req_valid[u] = 1'b0;
    rsp_ready[u] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] vals [8];
    int          prev_acc;

    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_write[u] = 1'b0; req_addr[u] = '0;
      req_wdata[u] = '0;   req_wstrb[u] = '0;   rsp_ready[u] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset req_ready", {31'h0, req_ready[0]}, 32'h1);
    chk("reset rsp_valid", {31'h0, rsp_valid[0]}, 32'h0);
    chk("reset rsp_rdata", rsp_rdata[0], 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // full-word store then load, with latency measured
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er);
    chk("store err", {31'h0, er}, 32'h0);
    chk("store rdata", rd, 32'h0);
    chk("store latency", 32'(rsp_cyc[0] - acc_cyc[0]), 32'd3);
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
    chk("load full word", rd, 32'hDEADBEEF);
    chk("load err", {31'h0, er}, 32'h0);
    chk("load latency", 32'(rsp_cyc[0] - acc_cyc[0]), 32'd3);

    // partial store merges with the existing word
    access(0, 1'b1, 32'h10, 32'h00001234, 4'b0011, 1, rd, er);
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
    chk("load merged", rd, 32'hDEAD1234);

    // misaligned and out-of-range accesses
    access(0, 1'b0, 32'h02, 32'h0, 4'h0, 0, rd, er);
    chk("misaligned err", {31'h0, er}, 32'h1);
    chk("misaligned rdata", rd, 32'h0);
    access(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 0, rd, er);
    chk("out of range err", {31'h0, er}, 32'h1);
    access(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er);
    chk("word 0 untouched", rd, 32'h0);
    chk("word 0 err", {31'h0, er}, 32'h0);

    // zero strobe store leaves memory as is
    access(0, 1'b1, 32'h10, 32'h0BADF00D, 4'h0, 0, rd, er);
    chk("wstrb0 err", {31'h0, er}, 32'h0);

    // response held for 5 cycles before being taken
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er);
    chk("stalled load", rd, 32'hDEAD1234);

    // reset during WAIT of a store aborts it
    req_write[0] = 1'b1; req_addr[0] = 32'h8; req_wdata[0] = 32'h55; req_wstrb[0] = 4'hF;
    req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort rsp_valid", {31'h0, rsp_valid[0]}, 32'h0);
    chk("abort req_ready", {31'h0, req_ready[0]}, 32'h1);
    repeat (3) @(negedge clk);
    access(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, rd, er);
    chk("aborted store not committed", rd, 32'h0);
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
    chk("reset cleared memory", rd, 32'h0);

    // zero latency: fill eight words, then stream loads back to back
    for (int i = 0; i < 8; i++) begin
      vals[i] = $urandom;
      access(1, 1'b1, 32'(i * 4), vals[i], 4'hF, 0, rd, er);
    end
    prev_acc = 0;
    for (int i = 0; i < 8; i++) begin
      access(1, 1'b0, 32'(i * 4), 32'h0, 4'h0, 0, rd, er);
      chk($sformatf("l0 load %0d", i), rd, vals[i]);
      if (i == 0) chk("l0 latency", 32'(rsp_cyc[1] - acc_cyc[1]), 32'd1);
      else chk($sformatf("l0 spacing %0d", i), 32'(acc_cyc[1] - prev_acc), 32'd2);
      prev_acc = acc_cyc[1];
    end

    // randomized traffic on both instances
    for (int n = 0; n < 300; n++) begin
      int u, r;
      logic [31:0] a;
      u = n % 2;
      r = $urandom_range(0, 9);
      if (r <= 6)      a = {24'h0, 6'($urandom), 2'b00};
      else if (r == 7) a = {24'h0, 6'($urandom), 2'($urandom_range(1, 3))};
      else if (r == 8) a = ($urandom | 32'h100) & 32'hFFFF_FFFC;
      else             a = $urandom;
      access(u, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(0, 3), rd, er);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
